// File: rtl/cmd_mem_arb.sv
// cmd_mem_arb: shares one command-memory read port among N_REQ requesters and routes each
// returned word back to its issuer through a fixed-latency one-hot tag pipeline.
// Build option: define CMD_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins);
// otherwise arbitration is round-robin starting after the most recently granted index.
module cmd_mem_arb #(
    parameter int N_REQ                = 4,
    parameter int CMD_ADDR_WIDTH       = 8,
    parameter int CMD_WIDTH            = 128,
    parameter int CMD_MEM_READ_LATENCY = 3
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [N_REQ-1:0]                  req,
    input  logic [N_REQ*CMD_ADDR_WIDTH-1:0]   addr,
    output logic [N_REQ-1:0]                  gnt,
    output logic                              mem_en,
    output logic [CMD_ADDR_WIDTH-1:0]         mem_addr,
    input  logic [CMD_WIDTH-1:0]              mem_data,
    output logic [N_REQ-1:0]                  rd_valid,
    output logic [CMD_WIDTH-1:0]              rd_data
);
    localparam int IW = $clog2(N_REQ);
    localparam int L  = CMD_MEM_READ_LATENCY;

    logic [N_REQ-1:0]          r_gnt;
    logic                      r_mem_en;
    logic [CMD_ADDR_WIDTH-1:0] r_mem_addr;
    logic [N_REQ-1:0]          r_tag [L+1];
    logic [CMD_WIDTH-1:0]      r_rd_data;
    logic [N_REQ-1:0]          w_elig;
    logic                      w_any;
    logic [IW-1:0]             w_win;
    int                        w_start;

    // a requester holding gnt this cycle is masked so a held req counts as a fresh request later
    assign w_elig = req & ~r_gnt;
    assign w_any  = |w_elig;

`ifdef CMD_MEM_ARB_FIXED_PRIO_EN
    assign w_start = 0;
`else
    logic [IW-1:0] r_last;

    assign w_start = (int'(r_last) + 1) % N_REQ;

    // remember the most recent winner; reset value gives requester 0 first priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= IW'(N_REQ - 1);
        end else if (w_any) begin
            r_last <= w_win;
        end
    end
`endif

    // scan downward so the last hit written is the first eligible index at or after w_start
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_elig[IW'((w_start + i) % N_REQ)]) w_win = IW'((w_start + i) % N_REQ);
        end
    end

    // register the grant pulse and memory command; address holds when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt      <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_gnt    <= w_any ? N_REQ'(1) << w_win : '0;
            r_mem_en <= w_any;
            if (w_any) r_mem_addr <= addr[w_win*CMD_ADDR_WIDTH +: CMD_ADDR_WIDTH];
        end
    end

    // carry each grant's one-hot tag alongside the memory latency; data captured as it lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= L; i++) r_tag[i] <= '0;
            r_rd_data <= '0;
        end else begin
            r_tag[0] <= r_gnt;
            for (int i = 1; i <= L; i++) r_tag[i] <= r_tag[i-1];
            if (|r_tag[L-1]) r_rd_data <= mem_data;
        end
    end

    assign gnt      = r_gnt;
    assign mem_en   = r_mem_en;
    assign mem_addr = r_mem_addr;
    assign rd_valid = r_tag[L];
    assign rd_data  = r_rd_data;
endmodule

// File: tb/tb_cmd_mem_arb.sv
// tb_cmd_mem_arb: directed and randomized checks of cmd_mem_arb against a cycle-level reference model
module tb_cmd_mem_arb;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 128;
    localparam int L  = 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N-1:0]  gnt, rd_valid;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, rd_data;
    logic [DW-1:0] dq [L];

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int           due;
        logic [N-1:0] tag;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    int            cyc    = 0;
    int            m_last = N - 1;
    logic [N-1:0]  m_gnt  = '0;
    logic          m_en   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_rd   = '0;

    always #5 clk = ~clk;

    cmd_mem_arb #(
        .N_REQ(N), .CMD_ADDR_WIDTH(AW), .CMD_WIDTH(DW), .CMD_MEM_READ_LATENCY(L)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {a, 8'h5A, {14{a ^ 8'hC3}}};
    endfunction

    // command BRAM: data for an enabled address is valid L cycles later, garbage otherwise
    always @(posedge clk) begin
        dq[0] <= mem_en ? word(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < L; i++) dq[i] <= dq[i-1];
    end
    assign mem_data = dq[L-1];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all(input logic [N-1:0] eg, input logic ee, input logic [AW-1:0] ea,
                           input logic [N-1:0] ev, input logic [DW-1:0] ed);
        chk("gnt", DW'(gnt), DW'(eg));
        chk("mem_en", DW'(mem_en), DW'(ee));
        chk("mem_addr", DW'(mem_addr), DW'(ea));
        chk("rd_valid", DW'(rd_valid), DW'(ev));
        chk("rd_data", rd_data, ed);
    endtask

    // one cycle: check outputs of this cycle, apply this cycle's inputs, predict the next cycle
    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        logic [N-1:0] ev = '0;
        int w = -1;
        @(negedge clk);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev   = rq[0].tag;
            m_rd = rq[0].data;
            void'(rq.pop_front());
        end
        chk_all(m_gnt, m_en, m_addr, ev, m_rd);
        req  = r;
        addr = a;
        for (int i = 1; i <= N; i++) begin
`ifdef CMD_MEM_ARB_FIXED_PRIO_EN
            int k = i - 1;
`else
            int k = (m_last + i) % N;
`endif
            if (w < 0 && r[k] && !m_gnt[k]) w = k;
        end
        m_gnt = '0;
        m_en  = 1'b0;
        if (w >= 0) begin
            m_gnt[w] = 1'b1;
            m_en     = 1'b1;
            m_addr   = a[w*AW +: AW];
            m_last   = w;
            rq.push_back(ret_t'{cyc + 2 + L, m_gnt, word(m_addr)});
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        #1;
        chk_all('0, 1'b0, '0, '0, '0);
        m_last = N - 1;
        m_gnt  = '0;
        m_en   = 1'b0;
        m_addr = '0;
        m_rd   = '0;
        rq.delete();
        repeat (2) @(negedge clk);
        chk_all('0, 1'b0, '0, '0, '0);
        reset_n = 1'b1;
    endtask

    // requesters obey the protocol: hold req/addr until granted, occasionally withdraw early
    task automatic rand_run(input int n);
        logic [N-1:0]    r = req;
        logic [N*AW-1:0] a = addr;
        repeat (n) begin
            for (int i = 0; i < N; i++) begin
                if (m_gnt[i] || !r[i]) begin
                    r[i]          = ($urandom_range(0, 99) < 60);
                    a[i*AW +: AW] = AW'($urandom);
                end else if ($urandom_range(0, 99) < 3) begin
                    r[i] = 1'b0;
                end
            end
            step(r, a);
        end
    endtask

    initial begin
        logic [N*AW-1:0] a;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // single read from requester 0 at address 5
        a = '0;
        a[0 +: AW] = 8'h05;
        step(4'b0001, a);
        step(4'b0000, a);
        idle(6);

        // full contention with distinct addresses
        a = {8'h40, 8'h30, 8'h20, 8'h10};
        repeat (12) step(4'b1111, a);
        idle(8);

        // back-to-back single requester, address bumped after each grant
        a = '0;
        a[2*AW +: AW] = 8'h80;
        repeat (8) begin
            if (m_gnt[2]) a[2*AW +: AW] = a[2*AW +: AW] + 8'd1;
            step(4'b0100, a);
        end
        idle(8);

        // fairness after idle: grant 3, then 1 and 3 together
        a = {8'h33, 8'h22, 8'h11, 8'h00};
        step(4'b1000, a);
        idle(4);
        repeat (4) step(4'b1010, a);
        idle(8);

        // reset mid-flight: four grants, reset two cycles after the last
        a = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        repeat (4) step(4'b1111, a);
        step(4'b0000, a);
        do_reset();
        idle(8);
        repeat (4) step(4'b1111, a);
        idle(8);

        // randomized traffic with a reset in the middle
        rand_run(300);
        do_reset();
        rand_run(300);
        idle(L + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_mem_arb.md
# cmd_mem_arb

Shares one command memory read port among N_REQ processor cores (or fake cores) that each issue instruction-pointer reads. Round-robin arbitration grants at most one read per cycle. Each read is tagged and tracked through a fixed-latency pipeline, so returned command words are routed back to the requester that issued them. Sits between the per-core `cmd_mem_iface` masters and the shared command BRAM.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `CMD_ADDR_WIDTH`, 8: command memory address width.
- `CMD_WIDTH`, 128: command word width.
- `CMD_MEM_READ_LATENCY`, 3: cycles from `mem_en` edge to valid `mem_data` (1..8).

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester read request, level.
- `addr`  in  N_REQ*CMD_ADDR_WIDTH  requester i address at `[i*CMD_ADDR_WIDTH +: CMD_ADDR_WIDTH]`.
- `gnt`  out  N_REQ  one-hot, one-cycle grant pulse.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  CMD_ADDR_WIDTH  memory read address.
- `mem_data`  in  CMD_WIDTH  memory read data.
- `rd_valid`  out  N_REQ  one-hot, one-cycle read-return strobe.
- `rd_data`  out  CMD_WIDTH  returned command word, broadcast to all requesters.

## Operation
- **Arbitration.** In cycle t the eligible set is `req & ~gnt`. A requester whose `gnt` is high in t is not eligible in t.
- **Round-robin search.** The search starts at index `last+1` (mod N_REQ), where `last` is the most recently granted index. `last` resets to N_REQ-1, so requester 0 has first priority after reset.
- **Grant registers.** If the eligible set is non-empty, the winner w is registered at edge t+1: `gnt[w]=1`, `mem_en=1`, `mem_addr=addr[w]`, `last=w`. Otherwise `gnt=0`, `mem_en=0`, and `mem_addr` holds its value.
- **Requester rules.**
  - Hold `req` and `addr` stable until `gnt` is seen.
  - `req` during the `gnt` cycle is ignored.
  - Holding `req` high after `gnt` is a new request, to be granted no sooner than 2 cycles after the previous grant.
- **Throughput.** Aggregate is one grant per cycle; each requester gets at most one grant per 2 cycles.
- **Tag pipeline.** A shift register of depth `CMD_MEM_READ_LATENCY+1` carries the valid bit and the one-hot tag of each grant.
- **Return.** On the cycle the tag reaches the end, `rd_valid` equals the tag and `rd_data` is registered from `mem_data`.
- **Ordering.** Returns occur in grant order and never collide, because there is one grant per cycle and the latency is fixed.
- **Deasserted request.** If `req` drops before grant, no access is issued for it. A request is never cancelled after grant: data is always returned.
- **Contention.** With all requesters asserting continuously, each is granted exactly once per N_REQ cycles while N_REQ ≥ 2.

## Timing
- Reset values: `gnt=0`, `mem_en=0`, `mem_addr=0`, `rd_valid=0`, `rd_data=0`, `last=N_REQ-1`, tag pipeline cleared.
- Request sampled at cycle t:
  - `gnt`, `mem_en`, `mem_addr` appear in cycle t+1.
  - `mem_data` is valid in cycle t+1+L, where L = `CMD_MEM_READ_LATENCY`.
  - `rd_valid` and `rd_data` appear in cycle t+2+L.
- Request-to-data latency is L+2 cycles.
- `rd_data` holds its value between strobes.
- Reset asserted mid-operation:
  - All outputs and the pipeline clear asynchronously; in-flight reads are dropped with no `rd_valid`.
  - After `reset_n` deasserts, the first grant can appear no earlier than 1 cycle after the first sampled request.
- Simultaneous return and new grant in the same cycle is normal and independent.

## Configuration
- `CMD_MEM_ARB_FIXED_PRIO_EN` defined: fixed priority, where the lowest eligible index wins and the `last` register is not implemented. All other timing is unchanged.
- Undefined (default): round-robin as above.

## Test plan
- **Single read.** L=3. `req[0]=1`, `addr0=8'h05` in cycle 0, memory returns `128'hA5` for addr 5 → `gnt[0]`, `mem_en`, `mem_addr=8'h05` in cycle 1; `rd_valid=4'b0001`, `rd_data=128'hA5` in cycle 5; no other strobes.
- **Full contention.** All 4 requesters hold `req` for 12 cycles from cycle 0 → grant order 0,1,2,3,0,1,2,3,…, one per cycle from cycle 1; `rd_valid` follows the same order starting cycle 5, each paired with its own address's data.
- **Back-to-back single requester.** `req[2]` held high with `addr` incrementing after each `gnt` → grants in cycles 1,3,5,7; `rd_valid[2]` in cycles 5,7,9,11.
- **Fairness after idle.** Grant to 3, then `req[1]` and `req[3]` rise together → 1 is granted first, then 3.
- **Reset mid-flight.** 4 grants issued, `reset_n` pulled low 2 cycles after the last grant → no `rd_valid` ever appears for those grants; all outputs read 0 during reset; the next request after release is granted to requester 0 first.
- **Fixed-priority build.** With `CMD_MEM_ARB_FIXED_PRIO_EN` defined, `req=4'b1010` held → alternates 1, 3 (1 is masked during its `gnt` cycle); `req=4'b1111` → grants 0,1,0,1,….
